// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// Module : button_conditioner_pkg
// Brief  : Shared defaults and width helper for the button conditioner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package button_conditioner_pkg;

  localparam int DEF_DB_CYCLES  = 8;
  localparam int DEF_SAMPLE_DIV = 1;

  // Counter width for values 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_channel.sv
// ============================================================================
// Module : btn_channel
// Brief  : One button: 2-flop sync, tick-gated debounce, press/release pulses,
//          optional hold counter when BTN_AUTOREPEAT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pb,
  output logic level,
  output logic press,
  output logic released
);

  localparam int CW = clog2_min1(DB_CYCLES);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          w_accept;
  logic          w_rise;
  logic          w_fall;
  logic          w_repeat;

  assign w_accept = tick && (r_sync2 != r_level) && (r_cnt == C_CNT_MAX);
  assign w_rise   = w_accept &  r_sync2;
  assign w_fall   = w_accept & ~r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= pb;
      r_sync2   <= r_sync1;
      // Pulses land on the same edge as the level update, so they are
      // one clk wide whatever the tick rate.
      r_press   <= w_rise | w_repeat;
      r_release <= w_fall;
      if (tick) begin
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_CNT_MAX) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int C_HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW         = clog2_min1(C_HOLD_MAX);

  logic [HW-1:0] r_hold;
  logic          r_first;
  logic [HW-1:0] w_limit;

  // First repeat waits the long delay, later ones the short period.
  assign w_limit  = r_first ? HW'(REPEAT_DELAY - 1) : HW'(REPEAT_PERIOD - 1);
  assign w_repeat = tick && r_level && !w_fall && (r_hold == w_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_first <= 1'b1;
    end else if (w_rise || !r_level) begin
      r_hold  <= '0;
      r_first <= 1'b1;
    end else if (tick) begin
      if (w_repeat) begin
        r_hold  <= '0;
        r_first <= 1'b0;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end
`else
  assign w_repeat = 1'b0;

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_unused
  end
`endif

  assign level    = r_level;
  assign press    = r_press;
  assign released = r_release;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module : button_conditioner
// Brief  : N-channel push-button front end with shared sample prescaler and
//          lowest-index press encoder. Auto-repeat via BTN_AUTOREPEAT_EN.
//          The release pulse port is named released (release is a keyword).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_CH-1:0]                 pb,
  output logic [N_CH-1:0]                 level,
  output logic [N_CH-1:0]                 press,
  output logic [N_CH-1:0]                 released,
  output logic                            any_press,
  output logic [clog2_min1(N_CH)-1:0]     press_idx
);

  localparam int IDX_W = clog2_min1(N_CH);
  localparam int DW    = clog2_min1(SAMPLE_DIV);
  localparam logic [DW-1:0] C_DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0] r_div;
  logic          w_tick;

  // With SAMPLE_DIV=1 the counter sits at 0 and tick is permanently high.
  assign w_tick = (r_div == C_DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (w_tick),
      .pb       (pb[g]),
      .level    (level[g]),
      .press    (press[g]),
      .released (released[g])
    );
  end

  always_comb begin
    any_press = |press;
    press_idx = '0;
    // Descending scan so the lowest set index is written last.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press[i]) press_idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module : tb_button_conditioner
// Brief  : Table-driven bench for button_conditioner (N_CH=4, DB_CYCLES=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] pb;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] released;
  logic       any_press;
  logic [1:0] press_idx;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  pb;
    int          waits;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic [3:0]  rel;
    logic        any;
    logic [1:0]  idx;
  } vec_t;

  vec_t vecs[22];

  button_conditioner #(
    .N_CH          (4),
    .SAMPLE_DIV    (1),
    .DB_CYCLES     (8),
    .REPEAT_DELAY  (50),
    .REPEAT_PERIOD (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb        (pb),
    .level     (level),
    .press     (press),
    .released  (released),
    .any_press (any_press),
    .press_idx (press_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input logic a, input logic [1:0] i);
    check({tag, "_level"},     int'(level),     int'(l));
    check({tag, "_press"},     int'(press),     int'(p));
    check({tag, "_release"},   int'(released),  int'(r));
    check({tag, "_any_press"}, int'(any_press), int'(a));
    check({tag, "_press_idx"}, int'(press_idx), int'(i));
  endtask

  initial begin
    int pr_off[$];
    int rl_off[$];
    int exp_off[$];

    checks   = 0;
    failures = 0;

    //            pb       wait  level    press    release  any   idx
    vecs[0]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[1]  = '{4'b0100,  9, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{4'b0100,  1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2};
    vecs[3]  = '{4'b0100,  1, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[4]  = '{4'b0101,  5, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[5]  = '{4'b0100, 12, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{4'b1110,  9, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[7]  = '{4'b1110,  1, 4'b1110, 4'b1010, 4'b0000, 1'b1, 2'd1};
    vecs[8]  = '{4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[9]  = '{4'b1010,  9, 4'b1110, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[10] = '{4'b1010,  1, 4'b1010, 4'b0000, 4'b0100, 1'b0, 2'd0};
    vecs[11] = '{4'b1010,  1, 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[12] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b1010, 1'b0, 2'd0};
    vecs[13] = '{4'b0001, 10, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0};
    vecs[14] = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    // seven-sample run on ch3 is one short of acceptance
    vecs[15] = '{4'b1001,  7, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[16] = '{4'b0001, 10, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    // eight-sample run is just enough
    vecs[17] = '{4'b1001,  8, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[18] = '{4'b0001,  2, 4'b1001, 4'b1000, 4'b0000, 1'b1, 2'd3};
    vecs[19] = '{4'b0001,  1, 4'b1001, 4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[20] = '{4'b0000,  7, 4'b0001, 4'b0000, 4'b1000, 1'b0, 2'd0};
    vecs[21] = '{4'b0000,  3, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0};

    // Power-on reset
    pb  = 4'b0000;
    rst = 1'b0;
    #1 rst = 1'b1;
    step(3);
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;

    for (int r = 0; r < 22; r++) begin
      pb = vecs[r].pb;
      step(vecs[r].waits);
      check_all($sformatf("row%0d", r), vecs[r].lvl, vecs[r].prs, vecs[r].rel,
                vecs[r].any, vecs[r].idx);
    end

    // Reset while ch0's counter is at 6, button still held
    pb = 4'b0001;
    step(8);
    rst = 1'b1;
    #1;
    check_all("midrst_in", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    step(2);
    check_all("midrst_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    step(9);
    check_all("midrst_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    step(1);
    check_all("midrst_press", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0);

    // Long hold on ch0 from the accept above, let go at offset 88
`ifdef BTN_AUTOREPEAT_EN
    exp_off = '{50, 60, 70, 80, 90};
`endif
    for (int k = 1; k <= 120; k++) begin
      step(1);
      if (press[0])    pr_off.push_back(k);
      if (released[0]) rl_off.push_back(k);
      if (k == 88) pb = 4'b0000;
    end
    check("hold_press_count", pr_off.size(), exp_off.size());
    for (int i = 0; i < exp_off.size() && i < pr_off.size(); i++)
      check($sformatf("hold_press_at%0d", i), pr_off[i], exp_off[i]);
    check("hold_release_count", rl_off.size(), 1);
    if (rl_off.size() > 0) check("hold_release_at", rl_off[0], 98);
    check_all("hold_end", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
